// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - microsequencer control, microcode-load and datapath-control signal bundle
interface control_unit_if;
  logic        start;
  logic [5:0]  start_addr;
  logic        uc_we;
  logic [5:0]  uc_addr;
  logic [23:0] uc_wdata;
  logic        x_valid;
  logic        x_ready;
  logic        cy;
  logic        neg;
  logic        zero;
  logic [2:0]  fld_A;
  logic [2:0]  fld_B;
  logic [2:0]  fld_C;
  logic        ldRF;
  logic        selR_in;
  logic        ldR_in;
  logic        ldR_out;
  logic [1:0]  alu_op;
  logic        busy;
  logic        done;
  logic        z_valid;
  logic [5:0]  upc;

  modport master (
    output start, start_addr, uc_we, uc_addr, uc_wdata, x_valid, cy, neg, zero,
    input  x_ready, fld_A, fld_B, fld_C, ldRF, selR_in, ldR_in, ldR_out, alu_op,
           busy, done, z_valid, upc
  );

  modport slave (
    input  start, start_addr, uc_we, uc_addr, uc_wdata, x_valid, cy, neg, zero,
    output x_ready, fld_A, fld_B, fld_C, ldRF, selR_in, ldR_in, ldR_out, alu_op,
           busy, done, z_valid, upc
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - microprogrammed sequencer with 64x24 writable control store
module control_unit (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      r_state;
  logic [23:0] r_mem [0:63];
  logic [5:0]  r_upc;
  logic        r_done;
  logic        r_z_valid;
  logic        r_busy;

  logic [23:0] w_word;
  logic [2:0]  w_cond;
  logic [5:0]  w_next;
  logic [5:0]  w_upc_inc;
  logic [5:0]  w_upc_next;
  logic        w_active;
  logic        w_stall;
  logic        w_issue;

  assign w_word    = r_mem[r_upc];
  assign w_cond    = w_word[8:6];
  assign w_next    = w_word[5:0];
  assign w_upc_inc = r_upc + 6'd1;
  assign w_active  = (r_state != S_IDLE);
  // A wait-for-input word only counts as issued in the cycle its input arrives.
  assign w_stall   = (w_cond == 3'b111) && !bus.x_valid;
  assign w_issue   = w_active && !w_stall;

  always_comb begin
    w_upc_next = w_upc_inc;
    case (w_cond)
      3'b001:  w_upc_next = w_next;
      3'b010:  w_upc_next = bus.zero ? w_next : w_upc_inc;
      3'b011:  w_upc_next = bus.neg ? w_next : w_upc_inc;
      3'b100:  w_upc_next = bus.cy ? w_next : w_upc_inc;
      3'b101:  w_upc_next = !bus.zero ? w_next : w_upc_inc;
      3'b110:  w_upc_next = r_upc;
      3'b111:  w_upc_next = bus.x_valid ? w_upc_inc : r_upc;
      default: w_upc_next = w_upc_inc;
    endcase
  end

  // Control store is only writable while idle and is deliberately never cleared.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.uc_we) begin
      r_mem[bus.uc_addr] <= bus.uc_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_upc     <= 6'd0;
      r_done    <= 1'b0;
      r_z_valid <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_z_valid <= w_issue && w_word[11];
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_upc   <= bus.start_addr;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_upc <= w_upc_next;
          if (w_cond == 3'b110) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_stall) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_upc <= w_upc_next;
          if (!w_stall) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fld_A   = w_word[23:21];
  assign bus.fld_B   = w_word[20:18];
  assign bus.fld_C   = w_word[17:15];
  assign bus.selR_in = w_word[13];
  assign bus.alu_op  = w_word[10:9];
  assign bus.ldRF    = w_issue && w_word[14];
  assign bus.ldR_in  = w_issue && w_word[12];
  assign bus.ldR_out = w_issue && w_word[11];
  assign bus.x_ready = w_active && (w_cond == 3'b111) && bus.x_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.z_valid = r_z_valid;
  assign bus.upc     = r_upc;
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports start input 1 (begin microprogram) and start_addr input 6 (first microword address).
REQ-004 SHALL have ports uc_we input 1, uc_addr input 6 and uc_wdata input 24 for microprogram memory writes.
REQ-005 SHALL have ports x_valid input 1 (datapath input word available) and x_ready output 1 (input word consumed).
REQ-006 SHALL have ports cy, neg and zero, each input 1, carrying the datapath ALU flags (combinational from the current operands).
REQ-007 SHALL have datapath-control outputs fld_A 3, fld_B 3, fld_C 3, ldRF 1, selR_in 1, ldR_in 1, ldR_out 1 and alu_op 2.
REQ-008 SHALL have status outputs busy 1, done 1, z_valid 1 and upc 6 (current microaddress).

Function
REQ-009 SHALL hold 64 x 24-bit microprogram memory with combinational read and no reset of its contents.
REQ-010 SHALL decode microword fields as: [23:21] fld_A, [20:18] fld_B, [17:15] fld_C, [14] ldRF, [13] selR_in, [12] ldR_in, [11] ldR_out, [10:9] alu_op, [8:6] cond, [5:0] next.
REQ-011 SHALL implement states IDLE, RUN and WAIT.
REQ-012 SHALL in IDLE write uc_wdata to mem[uc_addr] when uc_we=1; uc_we SHALL be ignored in RUN and WAIT.
REQ-013 SHALL in IDLE with start=1 load upc<=start_addr and enter RUN next cycle; a simultaneous uc_we write SHALL complete first, so the fetched word reflects it.
REQ-014 SHALL drive fld_A/B/C, selR_in and alu_op from mem[upc] in every state, and SHALL force ldRF, ldR_in and ldR_out to 0 outside RUN and during a stalled cond=111 cycle.
REQ-015 SHALL select the next upc in RUN by cond: 000 upc+1; 001 next; 010 zero?next:upc+1; 011 neg?next:upc+1; 100 cy?next:upc+1; 101 !zero?next:upc+1; 110 halt; 111 wait-for-input.
REQ-016 SHALL evaluate branch flags in the same cycle the microword is issued (zero added latency).
REQ-017 SHALL compute upc+1 modulo 64 (63 wraps to 0).
REQ-018 SHALL on cond=110 issue that word's enables, then enter IDLE with done=1 for exactly one cycle; upc holds.
REQ-019 SHALL on cond=111 with x_valid=0 enter WAIT, holding upc with enables suppressed; when x_valid=1 (in RUN or WAIT) SHALL issue the word's enables, assert x_ready for that one cycle, advance upc+1 and be in RUN.
REQ-020 SHALL assert z_valid for one cycle in the cycle after any issued word with ldR_out=1.
REQ-021 SHALL assert busy=1 exactly when the state is RUN or WAIT.
REQ-022 SHALL ignore start while busy=1.

Reset
REQ-023 SHALL on rst=1, asynchronously and regardless of state, set state=IDLE, upc=0, done=0, z_valid=0, x_ready=0, busy=0 and ldRF=ldR_in=ldR_out=0.
REQ-024 SHALL preserve memory contents across reset; an operation aborted by reset SHALL need a new start to resume.

Verification
REQ-025 SHALL pass: load mem[0]=ldRF add, cond 000; mem[1]=cond 110; start at 0 -> ldRF=1 in cycle 1, done=1 in cycle 3, busy=0 thereafter.
REQ-026 SHALL pass: mem[5] cond 010 next=9 with zero=1 -> upc=9 next cycle; with zero=0 -> upc=6.
REQ-027 SHALL pass: cond 111 word with ldR_in=1, x_valid low 4 cycles then high -> ldR_in=0 during the stall, ldR_in=1 and x_ready=1 in the same single cycle, then upc advances.
REQ-028 SHALL pass: word at upc=63 with cond 000 -> upc=0 next cycle.
REQ-029 SHALL pass: rst asserted mid-RUN at upc=12 -> upc=0, busy=0 immediately; uc_we during RUN leaves memory unchanged.
REQ-030 SHALL pass: word with ldR_out=1 issued in cycle N -> z_valid=1 in cycle N+1 only.
